// File: rtl/la_pkg.sv
// Shared constants for the logic-analyzer capture core: default geometry and
// the state encoding seen on state_o.
package la_pkg;

  localparam int LA_WIDTH  = 64;
  localparam int LA_ADDR_W = 10;

  typedef logic [1:0] la_state_t;

  localparam logic [1:0] LA_IDLE  = 2'd0;
  localparam logic [1:0] LA_ARMED = 2'd1;
  localparam logic [1:0] LA_POST  = 2'd2;
  localparam logic [1:0] LA_DONE  = 2'd3;

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer: one write port and one registered,
// read-first read port. No reset, so it maps onto block RAM.
module la_sample_ram
  import la_pkg::*;
#(
  parameter int WIDTH  = LA_WIDTH,
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Both blocks sample the array before the write lands: same-address reads see old data.
  always_ff @(posedge clk_i) begin
    rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/la_capture.sv
// Trigger-and-capture core: records the trace bus into a circular buffer while
// armed, fires on a masked-equality match and stops after N post-trigger samples.
module la_capture
  import la_pkg::*;
#(
  parameter int WIDTH  = LA_WIDTH,
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  trace_i,
  input  logic              arm_i,
  input  logic [WIDTH-1:0]  trig_value_i,
  input  logic [WIDTH-1:0]  trig_mask_i,
  input  logic [ADDR_W-1:0] posttrig_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic [ADDR_W-1:0] start_addr_o,
  output logic              wrapped_o
);

  la_state_t         state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] post_cnt, post_cnt_nxt;
  logic [ADDR_W-1:0] trig_addr, trig_addr_nxt;
  logic [ADDR_W-1:0] start_addr, start_addr_nxt;
  logic              wrapped, wrapped_nxt;
  logic              we;
  logic              match;
  logic              rd_valid;
  logic [WIDTH-1:0]  ram_q;

  assign match = ((trace_i ^ trig_value_i) & trig_mask_i) == '0;

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    post_cnt_nxt  = post_cnt;
    trig_addr_nxt = trig_addr;
    wrapped_nxt   = wrapped;
    we            = 1'b0;
    if (arm_i) begin
      // A (re)arm discards the cycle's sample and any pending trigger.
      wr_ptr_nxt   = '0;
      wrapped_nxt  = 1'b0;
      post_cnt_nxt = posttrig_i;
      state_nxt    = LA_ARMED;
    end else begin
      case (state)
        LA_ARMED: begin
          we         = 1'b1;
          wr_ptr_nxt = wr_ptr + 1'b1;
          if (wr_ptr == '1) wrapped_nxt = 1'b1;
          if (match) begin
            trig_addr_nxt = wr_ptr;
            state_nxt     = (post_cnt == '0) ? LA_DONE : LA_POST;
          end
        end
        LA_POST: begin
          we           = 1'b1;
          wr_ptr_nxt   = wr_ptr + 1'b1;
          post_cnt_nxt = post_cnt - 1'b1;
          if (wr_ptr == '1) wrapped_nxt = 1'b1;
          if (post_cnt == ADDR_W'(1)) state_nxt = LA_DONE;
        end
        default: ;
      endcase
    end
  end

  // Once wrapped, the next slot to be written is the oldest surviving sample.
  assign start_addr_nxt = wrapped_nxt ? wr_ptr_nxt : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= LA_IDLE;
      wr_ptr     <= '0;
      post_cnt   <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      wrapped    <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      post_cnt   <= post_cnt_nxt;
      trig_addr  <= trig_addr_nxt;
      start_addr <= start_addr_nxt;
      wrapped    <= wrapped_nxt;
      rd_valid   <= 1'b1;
    end
  end

  la_sample_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk_i),
    .we_i      (we),
    .wr_addr_i (wr_ptr),
    .wr_data_i (trace_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (ram_q)
  );

  // The RAM read register has no reset; gating keeps rd_data_o at 0 until the first read lands.
  assign rd_data_o    = rd_valid ? ram_q : '0;
  assign state_o      = state;
  assign done_o       = (state == LA_DONE);
  assign trig_addr_o  = trig_addr;
  assign start_addr_o = start_addr;
  assign wrapped_o    = wrapped;

endmodule

// File: tb/tb_la_capture.sv
// Directed bench for la_capture: a full-size instance plus a 16-deep instance
// for the wrap case, both checked against hand-computed values.
module tb_la_capture;
  import la_pkg::*;

  localparam int W   = 64;
  localparam int AW  = 10;
  localparam int AWS = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [W-1:0]   trace, trig_value, trig_mask;
  logic           arm, arm_w;
  logic [AW-1:0]  posttrig, rd_addr;
  logic [AWS-1:0] posttrig_w, rd_addr_w;

  logic [W-1:0]   rd_data, rd_data_w;
  logic [1:0]     state, state_w;
  logic           done, done_w, wrapped, wrapped_w;
  logic [AW-1:0]  trig_addr, start_addr;
  logic [AWS-1:0] trig_addr_w, start_addr_w;

  la_capture #(.WIDTH(W), .ADDR_W(AW)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .trace_i      (trace),
    .arm_i        (arm),
    .trig_value_i (trig_value),
    .trig_mask_i  (trig_mask),
    .posttrig_i   (posttrig),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .state_o      (state),
    .done_o       (done),
    .trig_addr_o  (trig_addr),
    .start_addr_o (start_addr),
    .wrapped_o    (wrapped)
  );

  la_capture #(.WIDTH(W), .ADDR_W(AWS)) u_dut_wrap (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .trace_i      (trace),
    .arm_i        (arm_w),
    .trig_value_i (trig_value),
    .trig_mask_i  (trig_mask),
    .posttrig_i   (posttrig_w),
    .rd_addr_i    (rd_addr_w),
    .rd_data_o    (rd_data_w),
    .state_o      (state_w),
    .done_o       (done_w),
    .trig_addr_o  (trig_addr_w),
    .start_addr_o (start_addr_w),
    .wrapped_o    (wrapped_w)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver: one clock; inputs change 1ns after the edge, trace counts up
  task automatic cycle();
    @(posedge clk);
    #1;
    trace = trace + 1;
  endtask

  task automatic read_main(input logic [AW-1:0] addr, input string tag);
    logic [W-1:0] exp;
    rd_addr = addr;
    cycle();
    exp = exp_q.pop_front();
    check(tag, rd_data, exp);
  endtask

  initial begin
    logic [W-1:0] first_sample;
    rst_n      = 1'b0;
    trace      = '0;
    arm        = 1'b0;
    arm_w      = 1'b0;
    trig_value = '0;
    trig_mask  = '0;
    posttrig   = '0;
    posttrig_w = '0;
    rd_addr    = '0;
    rd_addr_w  = '0;

    // reset
    repeat (100) cycle();
    check("rst_state", W'(state), W'(LA_IDLE));
    check("rst_done", W'(done), 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wrapped", W'(wrapped), 0);
    check("rst_trig_addr", W'(trig_addr), 0);
    check("rst_start_addr", W'(start_addr), 0);
    check("rst_wrap_state", W'(state_w), W'(LA_IDLE));
    rst_n = 1'b1;
    cycle();
    check("idle_after_rst", W'(state), W'(LA_IDLE));

    // basic trigger: sample 0x10 lands at address 0, trigger 0x7a at 0x6a
    trig_value = 64'h7a;
    trig_mask  = 64'hff;
    posttrig   = 10'd4;
    trace      = 64'h0f;
    arm        = 1'b1;
    cycle();
    arm = 1'b0;
    check("basic_armed", W'(state), W'(LA_ARMED));
    repeat (64'h7e - 64'h10) cycle();
    check("basic_post", W'(state), W'(LA_POST));
    check("basic_not_done", W'(done), 0);
    cycle();
    check("basic_done", W'(done), 1);
    check("basic_state_done", W'(state), W'(LA_DONE));
    check("basic_trig_addr", W'(trig_addr), 64'h6a);
    check("basic_wrapped", W'(wrapped), 0);
    check("basic_start_addr", W'(start_addr), 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(64'h7a + i);
    for (int i = 0; i < 5; i++) read_main(AW'(10'h6a + i), "basic_readback");
    exp_q.push_back(64'h10);
    read_main(10'h000, "basic_first_sample");
    check("basic_done_holds", W'(done), 1);

    // wrap on the 16-deep instance: sample 0 lands at address 0
    trig_value = 64'h32;
    trig_mask  = 64'hff;
    posttrig_w = 4'd3;
    trace      = '1;
    arm_w      = 1'b1;
    cycle();
    arm_w = 1'b0;
    repeat (64'h35) cycle();
    check("wrap_post", W'(state_w), W'(LA_POST));
    cycle();
    check("wrap_done", W'(done_w), 1);
    check("wrap_wrapped", W'(wrapped_w), 1);
    check("wrap_start_addr", W'(start_addr_w), 64'h6);
    check("wrap_trig_addr", W'(trig_addr_w), 64'h2);
    for (int i = 0; i < 16; i++) exp_q.push_back(64'h26 + i);
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] exp;
      rd_addr_w = 4'h6 + AWS'(i);
      cycle();
      exp = exp_q.pop_front();
      check("wrap_readback", rd_data_w, exp);
    end

    // zero mask: first evaluated sample triggers, nothing after it stored
    trig_mask = '0;
    posttrig  = '0;
    arm       = 1'b1;
    cycle();
    arm = 1'b0;
    first_sample = trace;
    check("mask0_armed", W'(state), W'(LA_ARMED));
    check("mask0_not_done", W'(done), 0);
    cycle();
    check("mask0_done", W'(done), 1);
    check("mask0_trig_addr", W'(trig_addr), 0);
    check("mask0_start_addr", W'(start_addr), 0);
    check("mask0_wrapped", W'(wrapped), 0);
    exp_q.push_back(first_sample);
    read_main(10'h000, "mask0_sample");
    exp_q.push_back(64'h11);
    read_main(10'h001, "mask0_next_untouched");

    // re-arm during POST, with the arm cycle carrying a matching sample
    trig_value = 64'h20;
    trig_mask  = 64'hff;
    posttrig   = 10'd10;
    trace      = 64'h0f;
    arm        = 1'b1;
    cycle();
    arm = 1'b0;
    repeat (64'h12) cycle();
    check("rearm_post", W'(state), W'(LA_POST));
    check("rearm_trig_addr1", W'(trig_addr), 64'h10);
    trace = 64'h20;
    arm   = 1'b1;
    cycle();
    arm = 1'b0;
    check("rearm_no_trigger", W'(state), W'(LA_ARMED));
    repeat (3) cycle();
    check("rearm_still_armed", W'(state), W'(LA_ARMED));
    trace = 64'h20;
    cycle();
    check("rearm_post2", W'(state), W'(LA_POST));
    check("rearm_trig_addr2", W'(trig_addr), 64'h3);

    // asynchronous reset between edges while in POST
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_state", W'(state), W'(LA_IDLE));
    check("areset_done", W'(done), 0);
    check("areset_trig_addr", W'(trig_addr), 0);
    check("areset_wrap_state", W'(state_w), W'(LA_IDLE));
    #2;
    rst_n = 1'b1;
    cycle();
    check("areset_stays_idle", W'(state), W'(LA_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
